button_debounce: RTL

- Conditions the raw user-button pad input before it reaches the button pad-mirror block.
- Synchronises the asynchronous pad into the wishbone clock domain and filters bounce with a per-edge stability counter.
- Presents a clean level plus single-cycle press/release pulses and a wrapping press counter, which the downstream mirror block drives onto io_out in place of the raw io_in bit.

---
 rtl/button_pkg.sv | 15 +
 rtl/button_sync2.sv | 30 +++
 rtl/button_debounce.sv | 130 +++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and widths for the user-button conditioning path.
package button_pkg;

  localparam int DEBOUNCE_CNT_W = 16;
  localparam int PRESS_CNT_W    = 8;
  localparam int LONG_CNT_W     = 24;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_PEND = 2'd1,
    PRESSED    = 2'd2,
    REL_PEND   = 2'd3
  } btn_state_t;

endpackage

// File: rtl/button_sync2.sv
// Two-flop synchroniser for an asynchronous pad; reset value and output polarity are inputs
// so the same cell serves any pad.
module button_sync2
  import button_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic invert,
  input  logic pad,
  output logic level
);

  logic meta;
  logic stable;

  // Nothing may sit between meta and stable, or the metastability window is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta   <= rst_val;
      stable <= rst_val;
    end else begin
      meta   <= pad;
      stable <= meta;
    end
  end

  assign level = stable ^ invert;

endmodule

// File: rtl/button_debounce.sv
// Button debouncer: sync + per-edge stability FSM giving level, press/release pulses, press count.
// Long-press detection is compiled in with BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce
  import button_pkg::*;
#(
  parameter logic [DEBOUNCE_CNT_W-1:0] DEBOUNCE_CYCLES = 16'd10000,
  parameter bit                        ACTIVE_LOW_BTN  = 1'b1,
  parameter logic [LONG_CNT_W-1:0]     LONG_CYCLES     = 24'd5000000
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   en_i,
  input  logic                   btn_raw_i,
  output logic                   btn_level_o,
  output logic                   btn_press_o,
  output logic                   btn_release_o,
  output logic [PRESS_CNT_W-1:0] press_count_o,
  output logic                   long_press_o
);

  logic                      btn_sync;
  logic                      btn_s;
  btn_state_t                state;
  logic [DEBOUNCE_CNT_W-1:0] cnt;
  logic                      pend_done;

  // Flops reset to the raw pad value that means "released".
  button_sync2 u_sync (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_i),
    .rst_val (ACTIVE_LOW_BTN),
    .invert  (ACTIVE_LOW_BTN),
    .pad     (btn_raw_i),
    .level   (btn_sync)
  );

  // Polarity-corrected sample is retimed once before the FSM; keeps sampling while disabled.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) btn_s <= 1'b0;
    else           btn_s <= btn_sync;
  end

  assign pend_done = (cnt == DEBOUNCE_CYCLES - 16'd1);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state         <= RELEASED;
      cnt           <= '0;
      btn_level_o   <= 1'b0;
      btn_press_o   <= 1'b0;
      btn_release_o <= 1'b0;
      press_count_o <= '0;
    end else begin
      btn_press_o   <= 1'b0;
      btn_release_o <= 1'b0;
      if (en_i) begin
        unique case (state)
          RELEASED: begin
            if (btn_s) begin
              state <= PRESS_PEND;
              cnt   <= '0;
            end
          end
          PRESS_PEND: begin
            if (!btn_s) begin
              state <= RELEASED;
              cnt   <= '0;
            end else if (pend_done) begin
              state         <= PRESSED;
              cnt           <= '0;
              btn_level_o   <= 1'b1;
              btn_press_o   <= 1'b1;
              press_count_o <= press_count_o + 8'd1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          PRESSED: begin
            if (!btn_s) begin
              state <= REL_PEND;
              cnt   <= '0;
            end
          end
          REL_PEND: begin
            if (btn_s) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (pend_done) begin
              state         <= RELEASED;
              cnt           <= '0;
              btn_level_o   <= 1'b0;
              btn_release_o <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        endcase
      end
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  logic [LONG_CNT_W-1:0] hold_cnt;
  logic                  enter_pressed;
  logic                  enter_released;

  assign enter_pressed  = en_i && btn_s &&
                          ((state == PRESS_PEND && pend_done) || state == REL_PEND);
  assign enter_released = en_i && !btn_s && state == REL_PEND && pend_done;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      hold_cnt     <= '0;
      long_press_o <= 1'b0;
    end else if (enter_pressed) begin
      hold_cnt <= '0;
    end else if (enter_released) begin
      hold_cnt     <= '0;
      long_press_o <= 1'b0;
    end else if (en_i && (state == PRESSED || state == REL_PEND) && hold_cnt != LONG_CYCLES) begin
      hold_cnt <= hold_cnt + 24'd1;
      if (hold_cnt + 24'd1 == LONG_CYCLES) long_press_o <= 1'b1;
    end
  end
`else
  // LONG_CYCLES is referenced so both builds share one parameter list.
  assign long_press_o = 1'b0 & (|LONG_CYCLES);
`endif

endmodule
